// File: rtl/rd_ws_capture.sv
// Memory-side responder for the go/rd/ds/ws read handshake.
// It generates wait states, steps the read address and captures read data into a FIFO.
module rd_ws_capture #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd,
  input  logic              ds,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ws,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

  logic              rd_q;
  logic [3:0]        wcnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic rd_rise;
  logic pop;
  logic accept;
  logic push;

  assign rd_rise = rd & ~rd_q;
  assign pop     = out_valid & out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign accept  = (count < DEPTH) | pop;
  assign push    = ds & accept;

  assign ws        = (wcnt != 4'd0);
  assign out_valid = (count != '0);
  assign fifo_full = (count == DEPTH);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= 1'b0;
      wcnt <= 4'd0;
    end else begin
      rd_q <= rd;
      if (rd_rise) begin
        wcnt <= WAIT_INIT;
      end else if (rd && (wcnt != 4'd0)) begin
        wcnt <= wcnt - 4'd1;
      end else if (!rd) begin
        wcnt <= 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr     <= '0;
      overflow <= 1'b0;
    end else if (ds) begin
      addr <= addr + ADDR_W'(1);
      if (!accept) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case (1'b1)
        push & ~pop: count <= count + (PW+1)'(1);
        pop & ~push: count <= count - (PW+1)'(1);
        default:     count <= count;
      endcase
    end
  end

endmodule
